// File: rtl/sort_bist.sv
// Built-in self-test for a three-input descending sorter: sweeps every operand
// combination, checks the sorter's results LAT cycles later, and reports a verdict.
module sort_bist #(
  parameter int width = 3,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [width-1:0]     a,
  output logic [width-1:0]     b,
  output logic [width-1:0]     c,
  input  logic [width-1:0]     no1,
  input  logic [width-1:0]     no2,
  input  logic [width-1:0]     no3,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [3*width:0]     err_cnt,
  output logic [3*width-1:0]   first_err
);

  localparam int IW = 3 * width;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [IW-1:0] IDX_MAX    = '1;
  localparam logic [2:0]    DRAIN_LAST = 3'(LAT - 1);

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [2:0]       drain_cnt;

  logic [width-1:0] hi, lo, s1, s2, s3;

  logic [IW-1:0]    exp_pipe [LAT];
  logic [IW-1:0]    idx_pipe [LAT];
  logic [LAT-1:0]   vld_pipe;

  logic             accept_start;
  logic             mismatch;

  assign a = idx[IW-1:2*width];
  assign b = idx[2*width-1:width];
  assign c = idx[width-1:0];

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

  assign accept_start = start && ((state == IDLE) || (state == DONE));
  assign mismatch     = vld_pipe[LAT-1] && ({no1, no2, no3} != exp_pipe[LAT-1]);

  // Reference sort: order a/b first, then slot c in relative to that pair.
  always_comb begin
    hi = a;
    lo = b;
    if (b > a) begin
      hi = b;
      lo = a;
    end
    s1 = hi;
    s2 = lo;
    s3 = c;
    if (c > hi) begin
      s1 = c;
      s2 = hi;
      s3 = lo;
    end else if (c > lo) begin
      s2 = c;
      s3 = lo;
    end
  end

  // Sweep control; idx parks on its final value so a, b, c hold after the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            idx   <= '0;
          end
        end
        RUN: begin
          if (idx == IDX_MAX) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST)
            state <= DONE;
          else
            drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Expected value, vector index and valid travel together to line up with the sorter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < LAT; i++) begin
        exp_pipe[i] <= '0;
        idx_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= (state == RUN);
      exp_pipe[0] <= {s1, s2, s3};
      idx_pipe[0] <= idx;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      first_err <= '0;
    end else if (accept_start) begin
      err_cnt   <= '0;
      first_err <= '0;
    end else if (mismatch) begin
      if (err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
      if (err_cnt == '0)
        first_err <= idx_pipe[LAT-1];
    end
  end

endmodule
